// File: rtl/muldiv_unit_pkg.sv
// muldiv_unit_pkg: shared operation/state encodings for the multiply/divide unit.
package muldiv_unit_pkg;
    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } md_op_t;
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_FIX
    } md_state_t;
    function automatic logic is_signed_op(md_op_t op);
        return op == MD_MULT || op == MD_DIV;
    endfunction
endpackage

// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: request/response bundle between the execute stage and the HI/LO unit.
interface muldiv_unit_if #(parameter int WIDTH = 32);
    import muldiv_unit_pkg::*;
    logic             req_valid;
    logic             req_ready;
    md_op_t           op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    modport master (output req_valid, op, a, b, flush, input req_ready, busy, done, hi, lo);
    modport slave  (input req_valid, op, a, b, flush, output req_ready, busy, done, hi, lo);
endinterface

// File: rtl/muldiv_unit_div_iter.sv
// muldiv_unit_div_iter: unsigned restoring divider, one quotient bit per cycle for WIDTH cycles.
module muldiv_unit_div_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             i_start,
    input  logic             i_flush,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic             o_last,
    output logic [WIDTH-1:0] o_quot,
    output logic [WIDTH-1:0] o_rem
);
    localparam int CW = $clog2(WIDTH);
    logic             r_busy;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_d;
    logic [WIDTH:0]   w_sh;
    logic [WIDTH:0]   w_diff;
    logic             w_ge;
    // Dividend bits shift out of r_q while quotient bits shift in behind them.
    assign w_sh   = {r_rem, r_q[WIDTH-1]};
    assign w_diff = w_sh - {1'b0, r_d};
    assign w_ge   = !w_diff[WIDTH];
    assign o_last = r_busy && r_cnt == CW'(WIDTH-1);
    assign o_quot = r_q;
    assign o_rem  = r_rem;
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
            r_q    <= '0;
            r_rem  <= '0;
            r_d    <= '0;
        end else if (i_start) begin
            r_busy <= 1'b1;
            r_cnt  <= '0;
            r_q    <= i_dividend;
            r_rem  <= '0;
            r_d    <= i_divisor;
        end else if (i_flush) begin
            r_busy <= 1'b0;
        end else if (r_busy) begin
            r_rem  <= w_ge ? w_diff[WIDTH-1:0] : w_sh[WIDTH-1:0];
            r_q    <= {r_q[WIDTH-2:0], w_ge};
            r_cnt  <= r_cnt + CW'(1);
            r_busy <= !o_last;
        end
    end
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: HI/LO owner executing MULT/MULTU with fixed latency and DIV/DIVU iteratively.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MUL_LATENCY = 3
) (
    input logic          clk,
    input logic          resetn,
    muldiv_unit_if.slave bus
);
    localparam int CW = MUL_LATENCY > 1 ? $clog2(MUL_LATENCY) : 1;
    md_state_t          r_state;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [2*WIDTH-1:0] r_prod;
    logic [CW-1:0]      r_cnt;
    logic               r_done;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               w_accept;
    logic               w_sgn;
    logic               w_start;
    logic               w_div_last;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [WIDTH-1:0]   w_quot;
    logic [WIDTH-1:0]   w_rem;
    logic [2*WIDTH-1:0] w_prod;
    assign w_accept = bus.req_valid && r_state == ST_IDLE && !bus.flush;
    assign w_sgn    = is_signed_op(bus.op);
    assign w_start  = w_accept && (bus.op == MD_DIV || bus.op == MD_DIVU);
    assign w_a_mag  = (w_sgn && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    assign w_b_mag  = (w_sgn && bus.b[WIDTH-1]) ? -bus.b : bus.b;
    // Sign-extending to 2*WIDTH makes one unsigned multiplier serve both MULT and MULTU.
    assign w_prod   = {{WIDTH{w_sgn & bus.a[WIDTH-1]}}, bus.a} * {{WIDTH{w_sgn & bus.b[WIDTH-1]}}, bus.b};
    assign bus.req_ready = r_state == ST_IDLE;
    assign bus.busy      = r_state != ST_IDLE;
    assign bus.done      = r_done;
    assign bus.hi        = r_hi;
    assign bus.lo        = r_lo;
    muldiv_unit_div_iter #(.WIDTH(WIDTH)) u_div (
        .clk        (clk),
        .resetn     (resetn),
        .i_start    (w_start),
        .i_flush    (bus.flush),
        .i_dividend (w_a_mag),
        .i_divisor  (w_b_mag),
        .o_last     (w_div_last),
        .o_quot     (w_quot),
        .o_rem      (w_rem)
    );
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
            r_hi    <= '0;
            r_lo    <= '0;
            r_prod  <= '0;
            r_cnt   <= '0;
            r_done  <= 1'b0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: if (w_accept) begin
                    case (bus.op)
                        MD_MTHI: r_hi <= bus.a;
                        MD_MTLO: r_lo <= bus.a;
                        MD_MULT, MD_MULTU: begin
                            r_prod  <= w_prod;
                            r_cnt   <= CW'(MUL_LATENCY-1);
                            r_state <= ST_MUL;
                        end
                        MD_DIV, MD_DIVU: begin
                            // A zero divisor keeps the all-ones quotient unsigned.
                            r_neg_q <= w_sgn && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]) && |bus.b;
                            r_neg_r <= w_sgn && bus.a[WIDTH-1];
                            r_state <= ST_DIV;
                        end
                        default: ;
                    endcase
                end
                ST_MUL: if (bus.flush) begin
                    r_state <= ST_IDLE;
                end else if (r_cnt == '0) begin
                    {r_hi, r_lo} <= r_prod;
                    r_done       <= 1'b1;
                    r_state      <= ST_IDLE;
                end else begin
                    r_cnt <= r_cnt - CW'(1);
                end
                ST_DIV: r_state <= bus.flush ? ST_IDLE : w_div_last ? ST_FIX : ST_DIV;
                default: begin
                    r_state <= ST_IDLE;
                    if (!bus.flush) begin
                        r_lo   <= r_neg_q ? -w_quot : w_quot;
                        r_hi   <= r_neg_r ? -w_rem : w_rem;
                        r_done <= 1'b1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: scoreboard bench for muldiv_unit (WIDTH=32, MUL_LATENCY=3).
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;
    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          due;
    } exp_t;
    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    int          cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;
    exp_t        sb[$];
    exp_t        m_e;
    logic [31:0] sh = '0;
    logic [31:0] sl = '0;
    bit          mt_phase = 1'b0;
    muldiv_unit_if #(.WIDTH(32)) bus ();
    muldiv_unit #(.WIDTH(32), .MUL_LATENCY(3)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    function automatic logic [63:0] model(md_op_t op, logic [31:0] a, logic [31:0] b);
        longint sa, sbv, q, r;
        bit s;
        s   = op == MD_MULT || op == MD_DIV;
        sa  = s ? longint'($signed(a)) : longint'({32'b0, a});
        sbv = s ? longint'($signed(b)) : longint'({32'b0, b});
        if (op == MD_MULT) return sa * sbv;
        if (op == MD_MULTU) return {32'b0, a} * {32'b0, b};
        if (b == 0) return {a, 32'hFFFF_FFFF};
        q = sa / sbv;
        r = sa % sbv;
        return {r[31:0], q[31:0]};
    endfunction
    always @(negedge clk) if (resetn) begin
        if (mt_phase) chk("mt_busy", bus.busy, 0);
        if (bus.done) begin
            if (sb.size() == 0) chk("spurious_done", bus.done, 0);
            else begin
                m_e = sb.pop_front();
                chk("done_hi", bus.hi, m_e.hi);
                chk("done_lo", bus.lo, m_e.lo);
                chk("done_cycle", cyc, m_e.due);
            end
        end
    end
    task automatic issue(md_op_t op, logic [31:0] a, logic [31:0] b, bit push);
        logic [63:0] m;
        int acc;
        @(negedge clk);
        bus.op = op;
        bus.a = a;
        bus.b = b;
        bus.req_valid = 1'b1;
        @(posedge clk);
        #1;
        acc = cyc;
        bus.req_valid = 1'b0;
        m = model(op, a, b);
        if (op == MD_MTHI) sh = a;
        else if (op == MD_MTLO) sl = a;
        else if (push) begin
            sb.push_back('{hi: m[63:32], lo: m[31:0], due: acc + ((op == MD_MULT || op == MD_MULTU) ? 3 : 33)});
            {sh, sl} = m;
        end
    endtask
    task automatic drain();
        int t = 0;
        while (sb.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("drain", sb.size(), 0);
        @(negedge clk);
    endtask
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        int t;
        bus.req_valid = 1'b0;
        bus.op = MD_MULT;
        bus.a = '0;
        bus.b = '0;
        bus.flush = 1'b0;
        #2 resetn = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_hi", bus.hi, 0);
        chk("rst_lo", bus.lo, 0);
        chk("rst_ready", bus.req_ready, 1);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        resetn = 1'b1;
        mt_phase = 1'b1;
        issue(MD_MTHI, 32'h1234_5678, 32'h0, 1'b0);
        issue(MD_MTLO, 32'h9ABC_DEF0, 32'h0, 1'b0);
        @(negedge clk);
        mt_phase = 1'b0;
        chk("mthi", bus.hi, 32'h1234_5678);
        chk("mtlo", bus.lo, 32'h9ABC_DEF0);
        issue(MD_MULT, 32'hFFFF_FFFE, 32'd3, 1'b1); drain();
        issue(MD_MULTU, 32'hFFFF_FFFE, 32'd3, 1'b1); drain();
        issue(MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1); drain();
        issue(MD_DIVU, 32'd7, 32'd2, 1'b1); drain();
        issue(MD_DIVU, 32'h55, 32'd0, 1'b1); drain();
        issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1); drain();
        issue(MD_DIV, 32'hFFFF_FF00, 32'd0, 1'b1); drain();
        for (int i = 0; i < 10; i++) begin
            issue(md_op_t'($urandom_range(0, 3)), $urandom, ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom, 1'b1);
            drain();
        end
        @(negedge clk);
        bus.op = MD_MTHI;
        bus.a = 32'hDEAD_BEEF;
        bus.req_valid = 1'b1;
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.flush = 1'b0;
        chk("flush_idle_hi", bus.hi, sh);
        chk("flush_idle_busy", bus.busy, 0);
        issue(MD_DIV, 32'd100, 32'd7, 1'b0);
        repeat (9) @(negedge clk);
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        chk("flush_ready", bus.req_ready, 1);
        chk("flush_busy", bus.busy, 0);
        chk("flush_hi", bus.hi, sh);
        chk("flush_lo", bus.lo, sl);
        repeat (40) @(negedge clk);
        issue(MD_MULT, 32'd5, 32'd5, 1'b1); drain();
        chk("mul55_lo", bus.lo, 25);
        chk("mul55_hi", bus.hi, 0);
        issue(MD_MULT, 32'd7, 32'd9, 1'b0);
        @(negedge clk);
        resetn = 1'b0;
        #1;
        chk("amid_hi", bus.hi, 0);
        chk("amid_lo", bus.lo, 0);
        chk("amid_busy", bus.busy, 0);
        chk("amid_ready", bus.req_ready, 1);
        sh = '0;
        sl = '0;
        @(negedge clk);
        resetn = 1'b1;
        repeat (6) @(negedge clk);
        chk("post_rst_hi", bus.hi, 0);
        issue(MD_MULT, 32'hFFFF_0000, 32'h0001_0000, 1'b1);
        t = 0;
        while (!bus.done && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("b2b_done_seen", bus.done, 1);
        chk("b2b_ready", bus.req_ready, 1);
        bus.op = MD_MTLO;
        bus.a = 32'hCAFE_F00D;
        bus.req_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        chk("b2b_lo", bus.lo, 32'hCAFE_F00D);
        chk("b2b_hi", bus.hi, 32'hFFFF_FFFF);
        drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised multiply/divide unit beside the single-cycle ALU in the execute stage.
- Owns the HI/LO architectural registers.
- Executes MULT/MULTU over a configurable multi-cycle latency and DIV/DIVU as an iterative restoring divider.
- MTHI/MTLO complete in one cycle; the pipeline stalls on busy and can abort an in-flight operation with flush.

Parameters:
WIDTH, 32, operand, HI and LO width (min 8)
MUL_LATENCY, 3, cycles from MULT accept to done (min 1)

Ports:
clk  in  1  clock, rising edge
resetn  in  1  asynchronous reset, active-low
req_valid  in  1  operation request
req_ready  out  1  unit can accept (state IDLE)
op  in  3  md_op_t: MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO
a  in  WIDTH  rs operand (dividend / multiplicand / MTHI-MTLO data)
b  in  WIDTH  rt operand (divisor / multiplier)
flush  in  1  abort in-flight operation (exception)
busy  out  1  MULT/DIV in progress
done  out  1  one-cycle pulse: HI/LO just updated by MULT/DIV
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register

Behaviour:
- Reset: asynchronous, active-low. Values on reset:
  - hi = lo = 0
  - state = IDLE, req_ready = 1
  - busy = 0, done = 0
  - counters cleared
- States: IDLE, MUL, DIV, FIX.
  - Accept = req_valid && req_ready; req_ready = (state == IDLE).
  - In non-IDLE states, a and b are ignored.
- MTHI/MTLO:
  - On the accept edge, hi (or lo) <= a.
  - State stays IDLE; no done pulse; busy stays 0.
- MULT/MULTU:
  - On accept, latch the full 2*WIDTH product: signed for MULT, unsigned for MULTU.
  - Go to MUL with cnt = MUL_LATENCY-1; decrement each cycle in MUL.
  - When cnt == 0: {hi,lo} <= product, done = 1 for that following cycle, return to IDLE.
  - MUL_LATENCY = 1: hi/lo update on the edge after accept.
- DIV/DIVU:
  - On accept, latch the magnitudes |a|, |b| (DIV) or raw values (DIVU), plus the result signs.
  - Go to DIV: one restoring quotient bit per cycle for WIDTH cycles.
  - Then FIX for one cycle:
    - Negate the quotient if the operand signs differ (DIV).
    - Negate the remainder if a was negative (DIV).
    - Commit lo <= quotient, hi <= remainder; done pulses; return to IDLE.
  - Total latency: WIDTH+1 cycles from accept edge to the hi/lo update.
  - Quotient truncates toward zero; remainder takes the sign of the dividend.
- Boundary cases:
  - Divide by zero: lo = all ones, hi = a (full latency retained).
  - DIV of MIN by -1: lo = MIN, hi = 0.
  - done and req_ready both high on the return-to-IDLE cycle: a new request may be accepted back-to-back.
- flush:
  - In MUL/DIV/FIX: next edge forces IDLE; hi/lo unchanged; no done.
  - In IDLE: blocks acceptance in that cycle (flush has priority over req_valid).
- busy = (state != IDLE).
- hi/lo change only on MTHI/MTLO accept or on MULT/DIV completion.
- Asynchronous reset mid-operation: immediately returns to the reset values; the partial result is discarded.

Decomposition:
- Shared package: md_op_t enum (3-bit encodings above) and md_state_t.
- Sub-module div_iter: the WIDTH-cycle restoring core with start/flush/done and unsigned quotient/remainder outputs.
- Sign handling and the multiply delay counter stay in muldiv_unit.

Test Plan:
- Reset then MTHI a=0x12345678, next cycle MTLO a=0x9ABCDEF0 -> hi=0x12345678, lo=0x9ABCDEF0, busy never high, no done.
- MULT a=0xFFFFFFFE (-2), b=3 -> after exactly 3 cycles done pulses, hi=0xFFFFFFFF, lo=0xFFFFFFFA. MULTU same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- DIV a=-7 (0xFFFFFFF9), b=2 -> done 33 cycles after accept, lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=7, b=2 -> lo=3, hi=1.
- DIVU a=0x55, b=0 -> lo=0xFFFFFFFF, hi=0x55. DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIV in flight, flush asserted at cycle 10 -> next cycle state IDLE, req_ready=1, no done, hi/lo hold prior values. Then a new MULT 5x5 -> lo=25, hi=0.
- resetn pulsed low mid-MULT -> hi=lo=0 immediately, busy=0. Back-to-back MULT then MTLO accepted on the done cycle -> lo = MTLO data, hi = MULT hi.
